// File: rtl/xdma_c2h_stream_arbiter_if.sv
// AXI-Stream bundle used on both sides of the C2H stream arbiter.
// The master side drives payload and tid, the slave side returns tready.
interface xdma_c2h_stream_arbiter_if #(
  parameter int TDATA_WIDTH = 512,
  parameter int TKEEP_WIDTH = 64,
  parameter int TUSER_WIDTH = 1
);
  logic                   tvalid;
  logic                   tready;
  logic                   tlast;
  logic [TDATA_WIDTH-1:0] tdata;
  logic [TKEEP_WIDTH-1:0] tkeep;
  logic [TUSER_WIDTH-1:0] tuser;
  logic                   tid;

  modport master (
    output tvalid, tlast, tdata, tkeep, tuser, tid,
    input  tready
  );

  modport slave (
    input  tvalid, tlast, tdata, tkeep, tuser,
    output tready
  );
endinterface

// File: rtl/xdma_c2h_stream_arbiter.sv
// Frame-atomic round-robin arbiter merging two CMAC RX streams onto the
// single XDMA C2H stream. A grant is held from the first beat until the
// beat carrying tlast is accepted; ties go to the source not served last.
// Output is a single register slice; each beat is tagged with its source.
module xdma_c2h_stream_arbiter #(
  parameter int TDATA_WIDTH = 512,
  parameter int TKEEP_WIDTH = 64,
  parameter int TUSER_WIDTH = 1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  xdma_clk,
  input  logic                  xdma_reset,
  xdma_c2h_stream_arbiter_if.slave  s0_axis,
  xdma_c2h_stream_arbiter_if.slave  s1_axis,
  xdma_c2h_stream_arbiter_if.master m_axis,
  output logic [CNT_WIDTH-1:0]  frame_cnt0,
  output logic [CNT_WIDTH-1:0]  frame_cnt1,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state_r;
  logic                   last_grant_r;
  logic                   busy_r;
  logic [CNT_WIDTH-1:0]   frame_cnt0_r;
  logic [CNT_WIDTH-1:0]   frame_cnt1_r;

  logic                   m_valid_r;
  logic                   m_last_r;
  logic                   m_tid_r;
  logic [TDATA_WIDTH-1:0] m_data_r;
  logic [TKEEP_WIDTH-1:0] m_keep_r;
  logic [TUSER_WIDTH-1:0] m_user_r;

  logic                   out_ready_s;
  logic                   s0_ready_s;
  logic                   s1_ready_s;
  logic                   acc0_s;
  logic                   acc1_s;
  logic                   acc_s;
  logic                   sel_last_s;
  logic [TDATA_WIDTH-1:0] sel_data_s;
  logic [TKEEP_WIDTH-1:0] sel_keep_s;
  logic [TUSER_WIDTH-1:0] sel_user_s;

  // Handshake decode: only the granted source sees the slice's readiness
  always_comb begin
    out_ready_s = !m_valid_r || m_axis.tready;
    s0_ready_s  = (state_r == BUSY0) && out_ready_s;
    s1_ready_s  = (state_r == BUSY1) && out_ready_s;
    acc0_s      = s0_ready_s && s0_axis.tvalid;
    acc1_s      = s1_ready_s && s1_axis.tvalid;
    acc_s       = acc0_s || acc1_s;
  end

  // Payload select from the granted source
  always_comb begin
    if (state_r == BUSY1) begin
      sel_data_s = s1_axis.tdata;
      sel_keep_s = s1_axis.tkeep;
      sel_user_s = s1_axis.tuser;
      sel_last_s = s1_axis.tlast;
    end else begin
      sel_data_s = s0_axis.tdata;
      sel_keep_s = s0_axis.tkeep;
      sel_user_s = s0_axis.tuser;
      sel_last_s = s0_axis.tlast;
    end
  end

  // Grant FSM with round-robin history, busy flag and per-source frame counters
  always_ff @(posedge xdma_clk or negedge xdma_reset) begin
    if (!xdma_reset) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      busy_r       <= 1'b0;
      frame_cnt0_r <= {CNT_WIDTH{1'b0}};
      frame_cnt1_r <= {CNT_WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (s0_axis.tvalid && (!s1_axis.tvalid || last_grant_r)) begin
            state_r <= BUSY0;
            busy_r  <= 1'b1;
          end else if (s1_axis.tvalid) begin
            state_r <= BUSY1;
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        BUSY0: begin
          if (acc0_s && s0_axis.tlast) begin
            state_r      <= IDLE;
            busy_r       <= 1'b0;
            last_grant_r <= 1'b0;
            frame_cnt0_r <= frame_cnt0_r + CNT_ONE;
          end else begin
            state_r <= BUSY0;
            busy_r  <= 1'b1;
          end
        end
        BUSY1: begin
          if (acc1_s && s1_axis.tlast) begin
            state_r      <= IDLE;
            busy_r       <= 1'b0;
            last_grant_r <= 1'b1;
            frame_cnt1_r <= frame_cnt1_r + CNT_ONE;
          end else begin
            state_r <= BUSY1;
            busy_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Output register slice: load on accept, drain when downstream takes the beat
  always_ff @(posedge xdma_clk or negedge xdma_reset) begin
    if (!xdma_reset) begin
      m_valid_r <= 1'b0;
      m_last_r  <= 1'b0;
      m_tid_r   <= 1'b0;
      m_data_r  <= {TDATA_WIDTH{1'b0}};
      m_keep_r  <= {TKEEP_WIDTH{1'b0}};
      m_user_r  <= {TUSER_WIDTH{1'b0}};
    end else if (acc_s) begin
      m_valid_r <= 1'b1;
      m_last_r  <= sel_last_s;
      m_tid_r   <= acc1_s;
      m_data_r  <= sel_data_s;
      m_keep_r  <= sel_keep_s;
      m_user_r  <= sel_user_s;
    end else if (m_axis.tready) begin
      m_valid_r <= 1'b0;
    end else begin
      m_valid_r <= m_valid_r;
    end
  end

  assign s0_axis.tready = s0_ready_s;
  assign s1_axis.tready = s1_ready_s;
  assign m_axis.tvalid  = m_valid_r;
  assign m_axis.tlast   = m_last_r;
  assign m_axis.tid     = m_tid_r;
  assign m_axis.tdata   = m_data_r;
  assign m_axis.tkeep   = m_keep_r;
  assign m_axis.tuser   = m_user_r;
  assign frame_cnt0     = frame_cnt0_r;
  assign frame_cnt1     = frame_cnt1_r;
  assign busy           = busy_r;

endmodule

// File: tb/tb_xdma_c2h_stream_arbiter.sv
// Self-checking bench for xdma_c2h_stream_arbiter: directed scenarios plus a
// randomized phase, checked every cycle against a behavioural model and an
// end-to-end per-source beat scoreboard.
module tb_xdma_c2h_stream_arbiter;
  localparam int CW  = 8;
  localparam int MOD = 1 << CW;

  typedef struct packed {
    logic [511:0] d;
    logic [63:0]  k;
    logic         u;
    logic         l;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m_tready = 1'b0;
  logic          sv[2];
  logic [511:0]  sdat[2];
  logic [63:0]   skeep[2];
  logic          suser[2];
  logic          slast[2];
  logic [CW-1:0] frame_cnt0, frame_cnt1;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tr_mode = 0;
  int pat = 0;
  bit gap_en = 1'b0;
  bit fire0 = 1'b0, fire1 = 1'b0, hold0 = 1'b0, hold1 = 1'b0;
  int acc0_cnt = 0;
  int sent[2];
  beat_t q0[$], q1[$], e0[$], e1[$];
  int mlog_tid[$], mlog_cyc[$];

  // model state
  int owner, prev, cnt0, cnt1;
  bit full;
  beat_t sl_b;
  int sl_id;
  bit in_frame, prev_stall;
  int frame_tid;
  logic [639:0] snap;

  xdma_c2h_stream_arbiter_if #(.TDATA_WIDTH(512), .TKEEP_WIDTH(64), .TUSER_WIDTH(1)) s0_if ();
  xdma_c2h_stream_arbiter_if #(.TDATA_WIDTH(512), .TKEEP_WIDTH(64), .TUSER_WIDTH(1)) s1_if ();
  xdma_c2h_stream_arbiter_if #(.TDATA_WIDTH(512), .TKEEP_WIDTH(64), .TUSER_WIDTH(1)) m_if ();

  assign s0_if.tvalid = sv[0];
  assign s0_if.tdata  = sdat[0];
  assign s0_if.tkeep  = skeep[0];
  assign s0_if.tuser  = suser[0];
  assign s0_if.tlast  = slast[0];
  assign s0_if.tid    = 1'b0;
  assign s1_if.tvalid = sv[1];
  assign s1_if.tdata  = sdat[1];
  assign s1_if.tkeep  = skeep[1];
  assign s1_if.tuser  = suser[1];
  assign s1_if.tlast  = slast[1];
  assign s1_if.tid    = 1'b1;
  assign m_if.tready  = m_tready;

  xdma_c2h_stream_arbiter #(.TDATA_WIDTH(512), .TKEEP_WIDTH(64), .TUSER_WIDTH(1), .CNT_WIDTH(CW)) dut (
    .xdma_clk   (clk),
    .xdma_reset (rst_n),
    .s0_axis    (s0_if),
    .s1_axis    (s1_if),
    .m_axis     (m_if),
    .frame_cnt0 (frame_cnt0),
    .frame_cnt1 (frame_cnt1),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [639:0] act, input logic [639:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add_frame(input int src, input int len, input bit rnd, input logic [31:0] tag);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      if (rnd) begin
        for (int j = 0; j < 16; j++) b.d[j*32 +: 32] = $urandom;
        b.k = {$urandom, $urandom};
        b.u = 1'($urandom_range(0, 1));
      end else begin
        b.d = {16{tag + 32'(i)}};
        b.k = 64'hFFFF_FFFF_FFFF_FFFF;
        b.u = 1'b0;
      end
      b.l = (i == len - 1);
      if (src == 0) begin q0.push_back(b); e0.push_back(b); end
      else begin q1.push_back(b); e1.push_back(b); end
    end
    sent[src]++;
  endtask

  // Call just after a negedge: asserts reset mid-cycle, clears sources, releases after two edges
  task automatic do_reset();
    #3;
    rst_n = 1'b0;
    q0.delete(); q1.delete(); e0.delete(); e1.delete();
    fire0 = 1'b0; fire1 = 1'b0; hold0 = 1'b0; hold1 = 1'b0;
    sv[0] = 1'b0; sv[1] = 1'b0;
    sent[0] = 0; sent[1] = 0;
    #1;
    chk("rst_m_tvalid", 640'(m_if.tvalid), 640'(0));
    chk("rst_s0_tready", 640'(s0_if.tready), 640'(0));
    chk("rst_s1_tready", 640'(s1_if.tready), 640'(0));
    chk("rst_busy", 640'(busy), 640'(0));
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || e0.size() != 0 || e1.size() != 0 || m_if.tvalid) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 640'(n < 5000), 640'(1));
  endtask

  // Source and sink driver: holds tvalid until accepted, optional gaps, tready pattern
  always @(posedge clk) begin
    #1;
    if (fire0) begin void'(q0.pop_front()); hold0 = 1'b0; fire0 = 1'b0; end
    if (fire1) begin void'(q1.pop_front()); hold1 = 1'b0; fire1 = 1'b0; end
    if (q0.size() != 0) begin
      if (!hold0) sv[0] = gap_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      {sdat[0], skeep[0], suser[0], slast[0]} = q0[0];
    end else sv[0] = 1'b0;
    hold0 = sv[0];
    if (q1.size() != 0) begin
      if (!hold1) sv[1] = gap_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      {sdat[1], skeep[1], suser[1], slast[1]} = q1[0];
    end else sv[1] = 1'b0;
    hold1 = sv[1];
    if (tr_mode == 0) m_tready = 1'b1;
    else if (tr_mode == 1) m_tready = (pat == 0);
    else m_tready = 1'($urandom_range(0, 1));
    pat = (pat + 1) % 3;
  end

  // Per-cycle compare against the behavioural model, scoreboard, then model step
  always @(negedge clk) begin
    int ob;
    bit room;
    beat_t b;
    cyc++;
    if (!rst_n) begin
      owner = -1; prev = 1; cnt0 = 0; cnt1 = 0; full = 1'b0;
      sl_b = '0; sl_id = 0; in_frame = 1'b0; prev_stall = 1'b0;
    end
    room = !full || m_tready;
    chk("busy", 640'(busy), 640'(owner >= 0));
    chk("s0_tready", 640'(s0_if.tready), 640'(rst_n && owner == 0 && room));
    chk("s1_tready", 640'(s1_if.tready), 640'(rst_n && owner == 1 && room));
    chk("m_tvalid", 640'(m_if.tvalid), 640'(full));
    chk("m_beat", 640'({m_if.tdata, m_if.tkeep, m_if.tuser, m_if.tlast}), 640'(sl_b));
    chk("m_tid", 640'(m_if.tid), 640'(sl_id));
    chk("frame_cnt0", 640'(frame_cnt0), 640'(cnt0));
    chk("frame_cnt1", 640'(frame_cnt1), 640'(cnt1));
    if (rst_n) begin
      if (prev_stall)
        chk("stall_hold", {m_if.tvalid, m_if.tid, m_if.tdata, m_if.tkeep, m_if.tuser, m_if.tlast}, snap);
      prev_stall = m_if.tvalid && !m_tready;
      snap = {m_if.tvalid, m_if.tid, m_if.tdata, m_if.tkeep, m_if.tuser, m_if.tlast};
      if (m_if.tvalid && m_tready) begin
        if (m_if.tid == 1'b0) begin
          chk("sb_expected0", 640'(e0.size() != 0), 640'(1));
          if (e0.size() != 0) begin b = e0.pop_front(); chk("sb_beat0", 640'({m_if.tdata, m_if.tkeep, m_if.tuser, m_if.tlast}), 640'(b)); end
        end else begin
          chk("sb_expected1", 640'(e1.size() != 0), 640'(1));
          if (e1.size() != 0) begin b = e1.pop_front(); chk("sb_beat1", 640'({m_if.tdata, m_if.tkeep, m_if.tuser, m_if.tlast}), 640'(b)); end
        end
        if (in_frame) chk("no_interleave", 640'(m_if.tid), 640'(frame_tid));
        in_frame = !m_if.tlast;
        frame_tid = int'(m_if.tid);
        mlog_tid.push_back(int'(m_if.tid));
        mlog_cyc.push_back(cyc);
      end
      fire0 = sv[0] && s0_if.tready;
      fire1 = sv[1] && s1_if.tready;
      if (fire0) acc0_cnt++;
      ob = owner;
      if (ob >= 0 && room && sv[ob]) begin
        sl_b = {sdat[ob], skeep[ob], suser[ob], slast[ob]};
        sl_id = ob;
        full = 1'b1;
        if (slast[ob]) begin
          if (ob == 0) cnt0 = (cnt0 + 1) % MOD; else cnt1 = (cnt1 + 1) % MOD;
          prev = ob;
          owner = -1;
        end
      end else if (m_tready) full = 1'b0;
      if (ob < 0) begin
        if (sv[0] && sv[1]) owner = 1 - prev;
        else if (sv[0]) owner = 0;
        else if (sv[1]) owner = 1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    sv[0] = 1'b0; sv[1] = 1'b0;
    sent[0] = 0; sent[1] = 0;
    repeat (2) @(negedge clk);
    chk("reset_m_tdata", 640'(m_if.tdata), 640'(0));
    chk("reset_cnt1", 640'(frame_cnt1), 640'(0));
    repeat (1) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // single 3-beat frame from source 0, literal timing
    add_frame(0, 3, 1'b0, 32'hA0);
    @(negedge clk);
    @(negedge clk);
    chk("t1_idle_tvalid", 640'(s0_if.tvalid), 640'(1));
    chk("t1_idle_tready", 640'(s0_if.tready), 640'(0));
    @(negedge clk);
    chk("t1_grant_tready", 640'(s0_if.tready), 640'(1));
    chk("t1_grant_mvalid", 640'(m_if.tvalid), 640'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t1_mvalid", 640'(m_if.tvalid), 640'(1));
      chk("t1_mdata", 640'(m_if.tdata), 640'({16{32'hA0 + 32'(i)}}));
      chk("t1_tid", 640'(m_if.tid), 640'(0));
      chk("t1_tlast", 640'(m_if.tlast), 640'(i == 2));
    end
    chk("t1_cnt0", 640'(frame_cnt0), 640'(1));

    // both sources backlogged from reset: alternate with one idle cycle between frames
    @(negedge clk);
    do_reset();
    add_frame(0, 2, 1'b0, 32'hB0); add_frame(1, 2, 1'b0, 32'hB8);
    add_frame(0, 2, 1'b0, 32'hB4); add_frame(1, 2, 1'b0, 32'hBC);
    mlog_tid.delete(); mlog_cyc.delete();
    wait_drain();
    chk("t2_beats", 640'(mlog_tid.size()), 640'(8));
    if (mlog_tid.size() == 8) begin
      for (int i = 0; i < 8; i++) chk("t2_order", 640'(mlog_tid[i]), 640'((i / 2) % 2));
      for (int i = 1; i < 8; i++) chk("t2_gap", 640'(mlog_cyc[i] - mlog_cyc[i-1]), 640'((i % 2 == 1) ? 1 : 2));
    end

    // source 1 frame under a 1,0,0 tready pattern
    @(posedge clk); #2;
    tr_mode = 1;
    add_frame(1, 4, 1'b1, 32'h0);
    wait_drain();
    chk("t3_cnt1", 640'(frame_cnt1), 640'(3));
    @(posedge clk); #2;
    tr_mode = 0;

    // source 1 arrives mid-frame of source 0 and must wait for tlast
    mlog_tid.delete(); mlog_cyc.delete();
    add_frame(0, 6, 1'b1, 32'h0);
    repeat (3) @(posedge clk);
    #2;
    add_frame(1, 2, 1'b1, 32'h0);
    repeat (2) @(negedge clk);
    chk("t4_s1_waiting", 640'(s1_if.tvalid), 640'(1));
    chk("t4_s1_blocked", 640'(s1_if.tready), 640'(0));
    wait_drain();
    chk("t4_beats", 640'(mlog_tid.size()), 640'(8));
    if (mlog_tid.size() == 8)
      for (int i = 0; i < 8; i++) chk("t4_order", 640'(mlog_tid[i]), 640'(i >= 6));

    // counter wrap on source 1
    @(negedge clk);
    do_reset();
    for (int i = 0; i < MOD - 1; i++) add_frame(1, 1, 1'b1, 32'h0);
    wait_drain();
    chk("t5_cnt1_max", 640'(frame_cnt1), 640'(MOD - 1));
    @(posedge clk); #2;
    add_frame(1, 1, 1'b1, 32'h0);
    wait_drain();
    chk("t5_cnt1_wrap", 640'(frame_cnt1), 640'(0));
    chk("t5_cnt0_same", 640'(frame_cnt0), 640'(0));

    // reset during beat 2 of a 4-beat frame, then recover
    @(posedge clk); #2;
    acc0_cnt = 0;
    add_frame(0, 4, 1'b0, 32'hC0);
    n = 0;
    while (acc0_cnt < 1 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    chk("t6_reached_beat2", 640'(n < 50), 640'(1));
    chk("t6_busy_before", 640'(busy), 640'(1));
    do_reset();
    add_frame(1, 3, 1'b1, 32'h0);
    wait_drain();
    chk("t6_cnt1", 640'(frame_cnt1), 640'(1));
    chk("t6_cnt0", 640'(frame_cnt0), 640'(0));

    // randomized traffic with valid gaps and random backpressure
    @(posedge clk); #2;
    gap_en = 1'b1;
    tr_mode = 2;
    for (int it = 0; it < 60; it++) begin
      for (int k = 0; k < 2; k++)
        if ($urandom_range(0, 1) == 1) add_frame($urandom_range(0, 1), $urandom_range(1, 6), 1'b1, 32'h0);
      repeat ($urandom_range(0, 12)) @(posedge clk);
      #2;
    end
    wait_drain();
    chk("rand_cnt0", 640'(frame_cnt0), 640'(sent[0] % MOD));
    chk("rand_cnt1", 640'(frame_cnt1), 640'(sent[1] % MOD));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
